mc_bus_interface: RTL
=====================

Name: mc_bus_interface

Overview:
- Bridges the MCU asynchronous parallel memory bus (mc_ce/mc_we/mc_oe/mc_add/mc_data) into the FPGA clock domain.
- Decodes writes into pushes on the command/data input FIFO or register-file writes.
- Serves reads from the output FIFO, the register file or a status word.
- Sits directly upstream of the bus pirate command FIFO/state machine inside top.

Parameters:
MC_DATA_WIDTH, 16, width of mc_data and all data paths
MC_ADD_WIDTH, 6, width of mc_add
SYNC_STAGES, 2, flip-flop stages on mc_ce/mc_we/mc_oe (minimum 2)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
mc_ce  in  1  chip enable, active low, async
mc_we  in  1  write strobe, active low, async
mc_oe  in  1  output enable, active low, async
mc_add  in  MC_ADD_WIDTH  bus address, async
mc_data_in  in  MC_DATA_WIDTH  bus data from pad
mc_data_out  out  MC_DATA_WIDTH  read data to pad
mc_data_oe  out  1  pad driver enable, 1 = FPGA drives mc_data
fifo_in_push  out  1  one-cycle push to input FIFO
fifo_in_data  out  MC_DATA_WIDTH  word pushed
fifo_in_cmd  out  1  1 = word is a command (addr 0x01), 0 = data (addr 0x00)
fifo_in_full  in  1  input FIFO full
fifo_out_pop  out  1  one-cycle pop from output FIFO
fifo_out_data  in  MC_DATA_WIDTH  output FIFO head word
fifo_out_empty  in  1  output FIFO empty
reg_wr_en  out  1  one-cycle register write strobe
reg_wr_add  out  MC_ADD_WIDTH  register write address
reg_wr_data  out  MC_DATA_WIDTH  register write data
reg_rd_add  out  MC_ADD_WIDTH  register read address (comb. lookup)
reg_rd_data  in  MC_DATA_WIDTH  register read data, valid same cycle
overflow  out  1  sticky: push dropped because FIFO was full
underflow  out  1  sticky: read of addr 0x00 while FIFO empty

Behaviour:
- Reset: all outputs 0; FSM to IDLE; sync chains preset to 1 (bus idle); sticky flags cleared.
- mc_ce/mc_we/mc_oe pass through SYNC_STAGES FFs. mc_add/mc_data_in are registered each cycle alongside the last sync stage, so address/data align with the synced strobes.
- Access is qualified by synced ce = 0; strobes while ce = 1 are ignored.
- FSM states: IDLE, WRITE, READ, READ_DONE.
- IDLE -> WRITE on synced we falling edge with ce = 0. IDLE -> READ on synced oe falling edge with ce = 0.
- If we and oe fall in the same cycle, write wins; oe is ignored until the next IDLE.
- WRITE: on synced we rising edge, act on the registered add/data, then return to IDLE. Exactly one action per transaction:
  - add 0x00: fifo_in_push = 1, fifo_in_cmd = 0.
  - add 0x01: fifo_in_push = 1, fifo_in_cmd = 1.
  - add 0x3F (status): ignored.
  - any other add: reg_wr_en = 1 with reg_wr_add/reg_wr_data.
  - If fifo_in_full when a push is due: no push, overflow = 1.
- READ: entered with mc_data_oe = 1; mc_data_out is registered one cycle after entry.
  - add 0x00: fifo_out_data, or 0 if fifo_out_empty (underflow = 1).
  - add 0x3F: status {12'b0, underflow, overflow, fifo_out_empty, fifo_in_full}.
  - otherwise: reg_rd_data at reg_rd_add = registered add.
  - mc_data_out stays frozen until the access ends.
- READ -> READ_DONE on synced oe rising edge: mc_data_oe = 0, and fifo_out_pop = 1 for one cycle if add was 0x00 and the FIFO was non-empty at read start. READ_DONE -> IDLE next cycle.
- Sticky flags clear only on reset or on a write to status address 0x3F (write ignored otherwise).
- ce rising mid-transaction: abort to IDLE, mc_data_oe = 0, no push/pop/write.
- Reset mid-operation: immediate return to IDLE, mc_data_oe = 0, no pending strobe issued.
- Strobe-to-action latency: SYNC_STAGES+1 cycles after the pad edge.

Decomposition:
- Shared package (registers.v): address constants MC_ADD_DATA = 6'h00, MC_ADD_CMD = 6'h01, MC_ADD_STATUS = 6'h3F; status bit indices; FSM state encodings.
- Sub-module: mc_sync, a parameterised N-stage synchroniser with preset-to-1 reset, instantiated three times for ce/we/oe.

Test Plan:
- Write 0x00AA to add 0x01, we low 6 clocks -> exactly one fifo_in_push, fifo_in_cmd = 1, fifo_in_data = 0x00AA, 3 cycles after the we rising edge.
- Write 0x00FF to add 0x05 -> reg_wr_en pulse, reg_wr_add = 5, reg_wr_data = 0x00FF; no FIFO push.
- fifo_in_full = 1, write 0x1234 to add 0x00 -> no push; read 0x3F returns 0x0005 (overflow|full); write 0x3F then read -> 0x0001.
- fifo_out_data = 0xBEEF, not empty, read add 0x00 -> mc_data_out = 0xBEEF while oe low; one fifo_out_pop after oe high; mc_data_oe = 0.
- fifo_out_empty = 1, read add 0x00 -> mc_data_out = 0, no pop, underflow = 1.
- Assert reset while we is low mid-write -> no push or reg_wr_en; all outputs 0; a following clean write succeeds.

Source files
------------

// File: rtl/mc_bus_interface_pkg.sv
// Shared constants for the MCU bus bridge: bus addresses, status bit layout and FSM encoding.
package mc_bus_interface_pkg;

  localparam logic [5:0] MC_ADD_DATA   = 6'h00;
  localparam logic [5:0] MC_ADD_CMD    = 6'h01;
  localparam logic [5:0] MC_ADD_STATUS = 6'h3F;

  localparam int STAT_FULL  = 0;
  localparam int STAT_EMPTY = 1;
  localparam int STAT_OVF   = 2;
  localparam int STAT_UNF   = 3;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITE     = 2'd1,
    ST_READ      = 2'd2,
    ST_READ_DONE = 2'd3
  } mc_state_e;

endpackage

// File: rtl/mc_sync.sv
// N-stage synchroniser for an asynchronous active-low strobe; resets to 1 so the bus looks idle.
module mc_sync #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clock) begin
    if (reset) sync_q <= '1;
    else       sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/mc_bus_interface.sv
// Bridges the MCU asynchronous memory bus into the clock domain: writes become FIFO pushes or
// register writes, reads are served from the output FIFO, the register file or the status word.
//
// state        | meaning
// ST_IDLE      | waiting for a qualified we/oe falling edge
// ST_WRITE     | we asserted; act once on its rising edge
// ST_READ      | driving mc_data; read word frozen once loaded
// ST_READ_DONE | oe released; one cycle gap before the next access
module mc_bus_interface
  import mc_bus_interface_pkg::*;
#(
  parameter int MC_DATA_WIDTH = 16,
  parameter int MC_ADD_WIDTH  = 6,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     mc_ce,
  input  logic                     mc_we,
  input  logic                     mc_oe,
  input  logic [MC_ADD_WIDTH-1:0]  mc_add,
  input  logic [MC_DATA_WIDTH-1:0] mc_data_in,
  output logic [MC_DATA_WIDTH-1:0] mc_data_out,
  output logic                     mc_data_oe,
  output logic                     fifo_in_push,
  output logic [MC_DATA_WIDTH-1:0] fifo_in_data,
  output logic                     fifo_in_cmd,
  input  logic                     fifo_in_full,
  output logic                     fifo_out_pop,
  input  logic [MC_DATA_WIDTH-1:0] fifo_out_data,
  input  logic                     fifo_out_empty,
  output logic                     reg_wr_en,
  output logic [MC_ADD_WIDTH-1:0]  reg_wr_add,
  output logic [MC_DATA_WIDTH-1:0] reg_wr_data,
  output logic [MC_ADD_WIDTH-1:0]  reg_rd_add,
  input  logic [MC_DATA_WIDTH-1:0] reg_rd_data,
  output logic                     overflow,
  output logic                     underflow
);

  localparam logic [MC_ADD_WIDTH-1:0] ADD_DATA   = MC_ADD_WIDTH'(MC_ADD_DATA);
  localparam logic [MC_ADD_WIDTH-1:0] ADD_CMD    = MC_ADD_WIDTH'(MC_ADD_CMD);
  localparam logic [MC_ADD_WIDTH-1:0] ADD_STATUS = MC_ADD_WIDTH'(MC_ADD_STATUS);

  logic ce_s, we_s, oe_s;
  logic we_prev_q, oe_prev_q;
  logic we_fall, we_rise, oe_fall, oe_rise;

  logic [MC_ADD_WIDTH-1:0]  add_pipe_q  [SYNC_STAGES];
  logic [MC_DATA_WIDTH-1:0] data_pipe_q [SYNC_STAGES];
  logic [MC_ADD_WIDTH-1:0]  add_s;
  logic [MC_DATA_WIDTH-1:0] data_s;

  mc_state_e state_q, state_d;
  logic rd_loaded_q, rd_loaded_d;
  logic pop_due_q, pop_due_d;

  logic [MC_DATA_WIDTH-1:0] mc_data_out_q, mc_data_out_d;
  logic                     mc_data_oe_q, mc_data_oe_d;
  logic                     fifo_in_push_q, fifo_in_push_d;
  logic [MC_DATA_WIDTH-1:0] fifo_in_data_q, fifo_in_data_d;
  logic                     fifo_in_cmd_q, fifo_in_cmd_d;
  logic                     fifo_out_pop_q, fifo_out_pop_d;
  logic                     reg_wr_en_q, reg_wr_en_d;
  logic [MC_ADD_WIDTH-1:0]  reg_wr_add_q, reg_wr_add_d;
  logic [MC_DATA_WIDTH-1:0] reg_wr_data_q, reg_wr_data_d;
  logic                     overflow_q, overflow_d;
  logic                     underflow_q, underflow_d;

  logic [MC_DATA_WIDTH-1:0] status_word;
  logic [MC_DATA_WIDTH-1:0] rd_word;

  mc_sync #(.STAGES(SYNC_STAGES)) u_sync_ce (.clock(clock), .reset(reset), .d(mc_ce), .q(ce_s));
  mc_sync #(.STAGES(SYNC_STAGES)) u_sync_we (.clock(clock), .reset(reset), .d(mc_we), .q(we_s));
  mc_sync #(.STAGES(SYNC_STAGES)) u_sync_oe (.clock(clock), .reset(reset), .d(mc_oe), .q(oe_s));

  // Address/data ride a pipeline as deep as the strobe synchronisers so both sample the same instant.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        add_pipe_q[i]  <= '0;
        data_pipe_q[i] <= '0;
      end
    end else begin
      add_pipe_q[0]  <= mc_add;
      data_pipe_q[0] <= mc_data_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        add_pipe_q[i]  <= add_pipe_q[i-1];
        data_pipe_q[i] <= data_pipe_q[i-1];
      end
    end
  end

  assign add_s  = add_pipe_q[SYNC_STAGES-1];
  assign data_s = data_pipe_q[SYNC_STAGES-1];

  assign we_fall = we_prev_q & ~we_s;
  assign we_rise = ~we_prev_q & we_s;
  assign oe_fall = oe_prev_q & ~oe_s;
  assign oe_rise = ~oe_prev_q & oe_s;

  always_comb begin
    status_word             = '0;
    status_word[STAT_FULL]  = fifo_in_full;
    status_word[STAT_EMPTY] = fifo_out_empty;
    status_word[STAT_OVF]   = overflow_q;
    status_word[STAT_UNF]   = underflow_q;
    if (add_s == ADD_DATA)        rd_word = fifo_out_empty ? '0 : fifo_out_data;
    else if (add_s == ADD_STATUS) rd_word = status_word;
    else                          rd_word = reg_rd_data;
  end

  always_comb begin
    state_d        = state_q;
    rd_loaded_d    = rd_loaded_q;
    pop_due_d      = pop_due_q;
    mc_data_out_d  = mc_data_out_q;
    mc_data_oe_d   = mc_data_oe_q;
    fifo_in_push_d = 1'b0;
    fifo_in_data_d = fifo_in_data_q;
    fifo_in_cmd_d  = fifo_in_cmd_q;
    fifo_out_pop_d = 1'b0;
    reg_wr_en_d    = 1'b0;
    reg_wr_add_d   = reg_wr_add_q;
    reg_wr_data_d  = reg_wr_data_q;
    overflow_d     = overflow_q;
    underflow_d    = underflow_q;

    case (state_q)
      ST_IDLE: begin
        mc_data_oe_d = 1'b0;
        rd_loaded_d  = 1'b0;
        // A simultaneous we/oe fall is treated as a write.
        if (!ce_s && we_fall) begin
          state_d = ST_WRITE;
        end else if (!ce_s && oe_fall) begin
          state_d      = ST_READ;
          mc_data_oe_d = 1'b1;
          pop_due_d    = (add_s == ADD_DATA) && !fifo_out_empty;
        end
      end

      ST_WRITE: begin
        if (ce_s) begin
          state_d = ST_IDLE;
        end else if (we_rise) begin
          state_d = ST_IDLE;
          if (add_s == ADD_STATUS) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
          end else if (add_s == ADD_DATA || add_s == ADD_CMD) begin
            if (fifo_in_full) begin
              overflow_d = 1'b1;
            end else begin
              fifo_in_push_d = 1'b1;
              fifo_in_data_d = data_s;
              fifo_in_cmd_d  = (add_s == ADD_CMD);
            end
          end else begin
            reg_wr_en_d   = 1'b1;
            reg_wr_add_d  = add_s;
            reg_wr_data_d = data_s;
          end
        end
      end

      ST_READ: begin
        if (ce_s) begin
          state_d      = ST_IDLE;
          mc_data_oe_d = 1'b0;
        end else if (oe_rise) begin
          state_d        = ST_READ_DONE;
          mc_data_oe_d   = 1'b0;
          fifo_out_pop_d = pop_due_q;
        end else if (!rd_loaded_q) begin
          rd_loaded_d   = 1'b1;
          mc_data_out_d = rd_word;
          if (add_s == ADD_DATA && fifo_out_empty) underflow_d = 1'b1;
        end
      end

      ST_READ_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d      = ST_IDLE;
        mc_data_oe_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      we_prev_q      <= 1'b1;
      oe_prev_q      <= 1'b1;
      rd_loaded_q    <= 1'b0;
      pop_due_q      <= 1'b0;
      mc_data_out_q  <= '0;
      mc_data_oe_q   <= 1'b0;
      fifo_in_push_q <= 1'b0;
      fifo_in_data_q <= '0;
      fifo_in_cmd_q  <= 1'b0;
      fifo_out_pop_q <= 1'b0;
      reg_wr_en_q    <= 1'b0;
      reg_wr_add_q   <= '0;
      reg_wr_data_q  <= '0;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      we_prev_q      <= we_s;
      oe_prev_q      <= oe_s;
      rd_loaded_q    <= rd_loaded_d;
      pop_due_q      <= pop_due_d;
      mc_data_out_q  <= mc_data_out_d;
      mc_data_oe_q   <= mc_data_oe_d;
      fifo_in_push_q <= fifo_in_push_d;
      fifo_in_data_q <= fifo_in_data_d;
      fifo_in_cmd_q  <= fifo_in_cmd_d;
      fifo_out_pop_q <= fifo_out_pop_d;
      reg_wr_en_q    <= reg_wr_en_d;
      reg_wr_add_q   <= reg_wr_add_d;
      reg_wr_data_q  <= reg_wr_data_d;
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
    end
  end

  assign mc_data_out  = mc_data_out_q;
  assign mc_data_oe   = mc_data_oe_q;
  assign fifo_in_push = fifo_in_push_q;
  assign fifo_in_data = fifo_in_data_q;
  assign fifo_in_cmd  = fifo_in_cmd_q;
  assign fifo_out_pop = fifo_out_pop_q;
  assign reg_wr_en    = reg_wr_en_q;
  assign reg_wr_add   = reg_wr_add_q;
  assign reg_wr_data  = reg_wr_data_q;
  assign reg_rd_add   = add_s;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule
